// File: rtl/ysyx_22050133_wb_pkg.sv
// Writeback scheduler shared types: register address width,
// source indices and the busy-register vector.
package ysyx_22050133_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int SRC_ALU    = 0;
  localparam int SRC_LSU    = 1;
  localparam int SRC_MDU    = 2;

  typedef logic [31:0] busy_t;

  function automatic logic busy_hit(
    input busy_t                  b,
    input logic [REG_ADDR_W-1:0]  r
  );
    return b[r];
  endfunction

endpackage

// File: rtl/ysyx_22050133_wb_arb.sv
// One-hot writeback arbiter; round-robin when
// YSYX_22050133_WB_RR_ARB_EN is defined, else fixed priority.
module ysyx_22050133_wb_arb #(
  parameter int NUM_SRC = 3
) (
`ifdef YSYX_22050133_WB_RR_ARB_EN
  input  logic               clk,
  input  logic               rst,
`endif
  input  logic [NUM_SRC-1:0] req_i,
  output logic [NUM_SRC-1:0] gnt_o
);

`ifdef YSYX_22050133_WB_RR_ARB_EN
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Search starts at the pointer and wraps modulo NUM_SRC.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    gidx  = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_SRC))
        sum = sum - (PW+1)'(NUM_SRC);
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gidx       = idx;
      end
    end
    ptr_d = ptr_q;
    if (found)
      ptr_d = (gidx == PW'(NUM_SRC-1)) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ysyx_22050133_wb_sched.sv
// Writeback scheduler: arbitration, busy scoreboard, issue stall.
// Arbitration mode selected by YSYX_22050133_WB_RR_ARB_EN.
module ysyx_22050133_wb_sched
  import ysyx_22050133_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_SRC    = 3,
  parameter int REG_NUM    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            req_valid,
  input  logic [NUM_SRC*5-1:0]          req_rd,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] req_data,
  output logic [NUM_SRC-1:0]            req_ready,
  output logic                          rf_wen,
  output logic [4:0]                    rf_rd,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  input  logic                          iss_valid,
  input  logic [4:0]                    iss_rs1,
  input  logic [4:0]                    iss_rs2,
  input  logic                          iss_use_rs1,
  input  logic                          iss_use_rs2,
  input  logic                          iss_wen,
  input  logic [4:0]                    iss_rd,
  output logic                          iss_stall
);

  logic [NUM_SRC-1:0]    gnt;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  logic [REG_NUM-1:0]    busy_q, busy_d;
  logic                  iss_set;

  ysyx_22050133_wb_arb #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
`ifdef YSYX_22050133_WB_RR_ARB_EN
    .clk   (clk),
    .rst   (rst),
`endif
    .req_i (req_valid),
    .gnt_o (gnt)
  );

  assign req_ready = rst ? '0 : gnt;
  assign xfer      = |req_ready;

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      win_rd   |= req_rd[i*REG_ADDR_W +: REG_ADDR_W]
                & {REG_ADDR_W{req_ready[i]}};
      win_data |= req_data[i*DATA_WIDTH +: DATA_WIDTH]
                & {DATA_WIDTH{req_ready[i]}};
    end
  end

  assign iss_stall = iss_valid & (
      (iss_use_rs1 & busy_hit(busy_q, iss_rs1))
    | (iss_use_rs2 & busy_hit(busy_q, iss_rs2))
    | (iss_wen     & busy_hit(busy_q, iss_rd)));

  assign iss_set = iss_valid & ~iss_stall & iss_wen
                 & (iss_rd != '0);

  // Clear first so a same-register set on this edge wins.
  always_comb begin
    busy_d = busy_q;
    if (xfer && win_rd != '0) busy_d[win_rd] = 1'b0;
    if (iss_set)              busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      rf_wen   <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      busy_q   <= busy_d;
      rf_wen   <= xfer && (win_rd != '0);
      rf_rd    <= win_rd;
      rf_wdata <= win_data;
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_wb_sched.sv
// Directed bench for the writeback scheduler.
// Define YSYX_22050133_WB_RR_ARB_EN to check round-robin grants.
module tb_ysyx_22050133_wb_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_valid;
  logic [14:0]  req_rd;
  logic [191:0] req_data;
  logic [2:0]   req_ready;
  logic         rf_wen;
  logic [4:0]   rf_rd;
  logic [63:0]  rf_wdata;
  logic         iss_valid;
  logic [4:0]   iss_rs1, iss_rs2, iss_rd;
  logic         iss_use_rs1, iss_use_rs2, iss_wen;
  logic         iss_stall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_22050133_wb_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rf_wen      (rf_wen),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .iss_valid   (iss_valid),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_use_rs1 (iss_use_rs1),
    .iss_use_rs2 (iss_use_rs2),
    .iss_wen     (iss_wen),
    .iss_rd      (iss_rd),
    .iss_stall   (iss_stall)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss_idle();
    iss_valid   = 1'b0;
    iss_use_rs1 = 1'b0;
    iss_use_rs2 = 1'b0;
    iss_wen     = 1'b0;
    iss_rs1     = '0;
    iss_rs2     = '0;
    iss_rd      = '0;
  endtask

  task automatic src(input int i, input logic [4:0] rd,
                     input logic [63:0] d);
    req_rd[i*5 +: 5]     = rd;
    req_data[i*64 +: 64] = d;
  endtask

  logic [2:0] exp_g [4];

  initial begin
    rst       = 1'b1;
    req_valid = 3'b111;
    req_rd    = '0;
    req_data  = '0;
    iss_idle();
    src(0, 5'd1, 64'h11);
    src(1, 5'd2, 64'h22);
    src(2, 5'd3, 64'h33);

    // reset with all sources requesting
    #1;
    chk("rst_ready0", req_ready, 3'b000);
    tick();
    chk("rst_ready1", req_ready, 3'b000);
    chk("rst_wen1", rf_wen, 1'b0);
    chk("rst_stall", iss_stall, 1'b0);
    tick();
    chk("rst_wen2", rf_wen, 1'b0);
    req_valid = '0;
    rst = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) begin
      iss_valid = 1'b1;
      iss_use_rs1 = 1'b1;
      iss_use_rs2 = 1'b1;
      iss_rs1 = 5'(r);
      iss_rs2 = 5'(r);
      #1;
      chk($sformatf("busy0_r%0d", r), iss_stall, 1'b0);
    end
    iss_idle();

    // single ALU write
    tick();
    src(0, 5'd5, 64'h1234);
    req_valid = 3'b001;
    #1;
    chk("single_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    chk("single_wen", rf_wen, 1'b1);
    chk("single_rd", rf_rd, 5'd5);
    chk("single_data", rf_wdata, 64'h1234);
    tick();
    chk("single_idle_wen", rf_wen, 1'b0);

    // contention from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    src(0, 5'd1, 64'hA1);
    src(1, 5'd2, 64'hB2);
    src(2, 5'd3, 64'hC3);
    req_valid = 3'b111;
`ifdef YSYX_22050133_WB_RR_ARB_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b010;
    exp_g[2] = 3'b100; exp_g[3] = 3'b001;
`else
    exp_g[0] = 3'b001; exp_g[1] = 3'b001;
    exp_g[2] = 3'b001; exp_g[3] = 3'b001;
`endif
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("cont_gnt%0d", c), req_ready, exp_g[c]);
      tick();
      chk($sformatf("cont_rd%0d", c), rf_rd,
          (exp_g[c] == 3'b001) ? 5'd1 :
          (exp_g[c] == 3'b010) ? 5'd2 : 5'd3);
    end
    req_valid = '0;
    tick();

    // RAW on x7
    iss_valid = 1'b1;
    iss_wen   = 1'b1;
    iss_rd    = 5'd7;
    #1;
    chk("raw_issue_rd7", iss_stall, 1'b0);
    tick();
    iss_wen     = 1'b0;
    iss_rd      = '0;
    iss_use_rs1 = 1'b1;
    iss_rs1     = 5'd7;
    #1;
    chk("raw_stall_c1", iss_stall, 1'b1);
    tick();
    chk("raw_stall_c2", iss_stall, 1'b1);
    src(1, 5'd7, 64'h77);
    req_valid = 3'b010;
    #1;
    chk("raw_lsu_ready", req_ready, 3'b010);
    chk("raw_stall_c3", iss_stall, 1'b1);
    tick();
    req_valid = '0;
    chk("raw_wen", rf_wen, 1'b1);
    chk("raw_rd", rf_rd, 5'd7);
    chk("raw_released", iss_stall, 1'b0);
    iss_idle();
    tick();

    // WAW and x0
    iss_valid = 1'b1;
    iss_wen   = 1'b1;
    iss_rd    = 5'd0;
    #1;
    chk("x0_issue", iss_stall, 1'b0);
    tick();
    iss_wen = 1'b0;
    iss_use_rs1 = 1'b1;
    iss_use_rs2 = 1'b1;
    #1;
    chk("x0_read", iss_stall, 1'b0);
    iss_use_rs1 = 1'b0;
    iss_use_rs2 = 1'b0;
    iss_wen = 1'b1;
    iss_rd  = 5'd3;
    #1;
    chk("waw_first", iss_stall, 1'b0);
    tick();
    chk("waw_second", iss_stall, 1'b1);
    tick();
    chk("waw_hold", iss_stall, 1'b1);
    iss_idle();
    src(1, 5'd0, 64'hDEAD);
    req_valid = 3'b010;
    #1;
    chk("x0_lsu_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    chk("x0_lsu_wen", rf_wen, 1'b0);

    // mid-operation reset
    iss_valid = 1'b1;
    iss_wen   = 1'b1;
    iss_rd    = 5'd9;
    tick();
    iss_idle();
    iss_valid = 1'b1;
    iss_use_rs1 = 1'b1;
    iss_rs1 = 5'd9;
    #1;
    chk("mid_busy9", iss_stall, 1'b1);
    iss_idle();
    src(2, 5'd9, 64'h99);
    req_valid = 3'b100;
    rst = 1'b1;
    #1;
    chk("mid_ready", req_ready, 3'b000);
    tick();
    rst = 1'b0;
    req_valid = '0;
    chk("mid_wen", rf_wen, 1'b0);
    iss_valid = 1'b1;
    iss_use_rs1 = 1'b1;
    iss_rs1 = 5'd9;
    #1;
    chk("mid_rs9", iss_stall, 1'b0);
    iss_rs1 = 5'd3;
    #1;
    chk("mid_rs3", iss_stall, 1'b0);
    iss_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
